// File: rtl/image_loader.sv
// Serial pixel collector: assembles numInputs pixels into a flat frame vector,
// strobes NNvalid once per frame and holds the frame until resultValid.
module image_loader #(
  parameter int dataWidth = 8,
  parameter int numInputs = 784
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataWidth-1:0]           pixelIn,
  input  logic                           pixelValid,
  output logic                           pixelReady,
  input  logic                           sofIn,
  input  logic                           resultValid,
  output logic [dataWidth*numInputs-1:0] NNin,
  output logic                           NNvalid,
  output logic                           busy,
  output logic                           frameErr
);

  localparam int CW = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam logic [CW-1:0] LAST = CW'(numInputs - 1);

  typedef enum logic [1:0] {LOAD, EMIT, WAIT} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [CW-1:0]                  slot;
  logic [dataWidth*numInputs-1:0] nnin_q, nnin_d;
  logic                           nnvalid_q, busy_q, frameerr_q, frameerr_d;
  logic                           accept;

  assign pixelReady = (state_q == LOAD) && !reset;
  assign accept     = pixelValid && pixelReady;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    nnin_d     = nnin_q;
    frameerr_d = 1'b0;
    // A start-of-frame beat always lands in slot 0, resynchronising the counter.
    slot       = sofIn ? '0 : count_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          nnin_d[int'(slot)*dataWidth +: dataWidth] = pixelIn;
          frameerr_d = sofIn && (count_q != '0);
          if (slot == LAST) begin
            count_d = '0;
            state_d = EMIT;
          end else begin
            count_d = slot + 1'b1;
          end
        end
      end
      EMIT:    state_d = WAIT;
      WAIT:    if (resultValid) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Strobes are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      count_q    <= '0;
      nnin_q     <= '0;
      nnvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      nnin_q     <= nnin_d;
      nnvalid_q  <= (state_d == EMIT);
      busy_q     <= (state_d == WAIT);
      frameerr_q <= frameerr_d;
    end
  end

  assign NNin     = nnin_q;
  assign NNvalid  = nnvalid_q;
  assign busy     = busy_q;
  assign frameErr = frameerr_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomised bench for image_loader: a frame-array model is checked against the
// DUT on every cycle, plus literal expectations at key points of each scenario.
module tb_image_loader;
  localparam int DW = 8;
  localparam int N  = 784;

  logic            clk = 1'b0;
  logic            reset, pixelValid, sofIn, resultValid;
  logic [DW-1:0]   pixelIn;
  logic            pixelReady, NNvalid, busy, frameErr;
  logic [DW*N-1:0] NNin;

  always #5 clk = ~clk;

  image_loader #(.dataWidth(DW), .numInputs(N)) dut (
    .clk(clk), .reset(reset), .pixelIn(pixelIn), .pixelValid(pixelValid),
    .pixelReady(pixelReady), .sofIn(sofIn), .resultValid(resultValid),
    .NNin(NNin), .NNvalid(NNvalid), .busy(busy), .frameErr(frameErr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot_of(input int k);
    return NNin[k*DW +: DW];
  endfunction

  // Model: phase 0 = collecting, 1 = frame just completed, 2 = awaiting result.
  logic [DW-1:0] m_frame [N];
  int  m_phase = 0;
  int  m_cnt   = 0;
  bit  m_valid, m_busy, m_err;
  bit  m_on = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_phase = 0; m_cnt = 0;
      foreach (m_frame[k]) m_frame[k] = '0;
      m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    end else if (m_on) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (m_phase == 0 && pixelValid) begin
        int s;
        s = sofIn ? 0 : m_cnt;
        m_err = sofIn && (m_cnt != 0);
        m_frame[s] = pixelIn;
        m_cnt = s + 1;
        if (m_cnt == N) begin
          m_cnt = 0; m_phase = 1; m_valid = 1'b1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && resultValid) begin
        m_phase = 0;
      end
      m_busy = (m_phase == 2);
    end
  end

  int nv_cnt = 0;
  int fe_cnt = 0;

  always @(negedge clk) begin
    if (m_on) begin
      int bad;
      chk("pixelReady", pixelReady, (m_phase == 0) && !reset);
      chk("NNvalid", NNvalid, m_valid);
      chk("busy", busy, m_busy);
      chk("frameErr", frameErr, m_err);
      bad = -1;
      for (int k = 0; k < N; k++) begin
        if (bad < 0 && NNin[k*DW +: DW] !== m_frame[k]) bad = k;
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL NNin slot %0d: got %0h expected %0h", bad, NNin[bad*DW +: DW], m_frame[bad]);
      end
      if (NNvalid === 1'b1) nv_cnt++;
      if (frameErr === 1'b1) fe_cnt++;
    end
  end

  bit rv_noise = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] px, input bit sof, input int gap);
    bit acc;
    int t;
    for (int g = 0; g < gap; g++) begin
      pixelValid = 1'b0;
      resultValid = rv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    pixelValid = 1'b1; pixelIn = px; sofIn = sof;
    acc = 1'b0; t = 0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = pixelReady;
      step();
      t++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
    pixelValid = 1'b0; sofIn = 1'b0;
  endtask

  task automatic release_result();
    resultValid = 1'b1;
    step();
    resultValid = 1'b0;
  endtask

  int nv0, fe0, e;
  bit acc;

  initial begin
    reset = 1'b1; pixelValid = 1'b0; sofIn = 1'b0; resultValid = 1'b0; pixelIn = '0;
    repeat (3) step();
    chk("reset_NNin_zero", 32'(NNin === '0), 1);
    chk("reset_ready_low", pixelReady, 0);
    reset = 1'b0;

    // Full frame at full rate
    for (int k = 0; k < N; k++) send(DW'(k % 256), k == 0, 0);
    chk("t1_nnvalid_after_last", NNvalid, 1);
    chk("t1_slot5", slot_of(5), 5);
    chk("t1_slot300", slot_of(300), 44);
    chk("t1_slot783", slot_of(783), 15);
    step();
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", pixelReady, 0);
    chk("t1_nv_count", nv_cnt, 1);
    repeat (5) step();
    release_result();

    // Gapped stream, resultValid noise in LOAD and EMIT, beat held through WAIT
    rv_noise = 1'b1;
    for (int k = 0; k < N; k++) send(DW'(255 - k), k == 0, $urandom_range(0, 3));
    rv_noise = 1'b0;
    resultValid = 1'b1;
    pixelValid = 1'b1; pixelIn = 8'hAA; sofIn = 1'b0;
    step();
    resultValid = 1'b0;
    chk("t2_slot0", slot_of(0), 255);
    chk("t2_slot10", slot_of(10), 245);
    chk("t2_slot300", slot_of(300), 211);
    repeat (8) step();
    chk("t2_busy_held", busy, 1);
    chk("t2_nv_count", nv_cnt, 2);
    resultValid = 1'b1;
    e = 0; acc = 1'b0;
    while (!acc && e < 10) begin
      @(negedge clk);
      acc = pixelReady && pixelValid;
      step();
      resultValid = 1'b0;
      e++;
    end
    chk("t2_first_accept_edge", e, 2);
    pixelValid = 1'b0;

    // Resync: 100 x 0xAA (first already accepted), then sof 0x11 and 783 x 0x22
    for (int k = 0; k < 99; k++) send(8'hAA, 1'b0, 0);
    fe0 = fe_cnt;
    send(8'h11, 1'b1, 0);
    chk("t3_frameErr_pulse", frameErr, 1);
    for (int k = 0; k < N - 1; k++) send(8'h22, 1'b0, $urandom_range(0, 1));
    chk("t3_nnvalid", NNvalid, 1);
    chk("t3_frameErr_count", fe_cnt - fe0, 1);
    chk("t3_slot0", slot_of(0), 8'h11);
    chk("t3_slot1", slot_of(1), 8'h22);
    chk("t3_slot783", slot_of(783), 8'h22);
    step();
    release_result();

    // Reset mid-frame
    nv0 = nv_cnt;
    for (int k = 0; k < 400; k++) send(DW'($urandom), k == 0, 0);
    reset = 1'b1;
    step(); step();
    chk("t4_NNin_zero", 32'(NNin === '0), 1);
    chk("t4_ready_in_reset", pixelReady, 0);
    reset = 1'b0;
    step();
    chk("t4_no_nnvalid", nv_cnt, nv0);
    for (int k = 0; k < N; k++) send(DW'($urandom), 1'b0, 0);
    step();
    chk("t4_frame_after_reset", nv_cnt, nv0 + 1);

    // Reset during WAIT
    repeat (3) step();
    chk("t5_busy_before", busy, 1);
    reset = 1'b1;
    step();
    chk("t5_busy_dropped", busy, 0);
    reset = 1'b0;
    #1;
    chk("t5_ready_after_reset", pixelReady, 1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
